dma_job_ctrl: RTL and testbench
===============================

# dma_job_ctrl

Multi-job DMA control front end for the Snappy decompressor. It is the parametrised successor of the single-job AXI I/O wrapper. It accepts queued job descriptors and starts the decompressor once per job. For each job it generates 4 KB-safe read and write burst requests, byte-reverses data between host order and decompressor order, and reports completion per job with an ID and an error flag. The decompressor core sits outside this block and connects through the dec_* ports.

## Interface
Parameters:
- ADDR_W, 64, host address width.
- DATA_W, 512, data bus width; BYTES = DATA_W/8 (power of 2).
- QUEUE_DEPTH, 4, job descriptor FIFO depth (power of 2, ≥2).
- MAX_BURST, 64, maximum beats per burst (≤256).
- MAX_WR_OUT, 8, maximum write bursts requested but not yet B-acknowledged.
- ID_W, 4, job ID width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- job_valid / job_ready  in/out  1  descriptor push handshake.
- job_id  in  ID_W  tag returned on completion.
- job_src_addr, job_des_addr  in  ADDR_W  byte addresses; bits [log2(BYTES)-1:0] are ignored and forced to 0.
- job_comp_len, job_decomp_len  in  32  byte lengths.
- done_valid  out  1  one-cycle completion pulse.
- done_id  out  ID_W  ID of the completed job.
- done_err  out  1  job rejected (a length was zero).
- idle  out  1  queue empty and FSM in IDLE.
- rd_req  out  1  read request; held until acknowledged.
- rd_addr  out  ADDR_W  read burst address.
- rd_len  out  8  read burst length, beats−1.
- rd_req_ack  in  1  read request accepted.
- rd_data  in  DATA_W  read data in host order.
- rd_data_valid  in  1  read data valid.
- rd_data_taken  out  1  read data accepted; equals ~dec_almostfull.
- dec_start  out  1  one-cycle pulse that starts the decompressor.
- dec_comp_len  out  35  compressed length, zero-extended.
- dec_decomp_len  out  32  decompressed length.
- dec_data, dec_valid  out  DATA_W, 1  byte-reversed rd_data and rd_data_valid.
- dec_almostfull  in  1  decompressor input backpressure.
- dec_out, dec_out_strb  in  DATA_W, BYTES  decompressor output data and byte strobes.
- dec_done  in  1  decompressor finished the current job.
- wr_req  out  1  write request; held until acknowledged.
- wr_addr  out  ADDR_W  write burst address.
- wr_len  out  8  write burst length, beats−1.
- wr_req_ack  in  1  write request accepted.
- wr_data, wr_strb  out  DATA_W, BYTES  byte-reversed dec_out and bit-reversed dec_out_strb.
- wr_valid, wr_ready, bresp  in, in, in  1  beat handshake and B-response pulse (one per burst).
- bready  out  1  always 1 outside reset.

## Operation
- Byte reversal: byte i of dec_data = byte BYTES−1−i of rd_data. The same mapping applies from dec_out to wr_data, and bit i of dec_out_strb drives bit BYTES−1−i of wr_strb. This path is combinational and carries no state.
- Descriptor FIFO:
  - job_ready = !full.
  - A push occurs when job_valid & job_ready.
  - The head entry is popped in DONE.
- Beat counts:
  - rd_beats = ceil(comp_len/BYTES).
  - wr_beats = ceil(decomp_len/BYTES).
  - Both are 32-bit arithmetic with no overflow.
- Burst split:
  - beats = min(remaining, MAX_BURST, (4096 − addr[11:0])/BYTES).
  - len = beats−1.
  - On each ack: addr += beats·BYTES and remaining −= beats.
- FSM:
  - IDLE: when the FIFO is non-empty, latch the head entry. If either length is 0, go to DONE with err=1; otherwise go to START.
  - START: assert dec_start for exactly one cycle, clear counters, go to RUN.
  - RUN:
    - The read generator asserts rd_req while rd_remaining>0.
    - The write generator asserts wr_req while wr_remaining>0 and outstanding<MAX_WR_OUT.
    - outstanding is +1 on wr_req&wr_req_ack and −1 on bresp. When both happen in the same cycle, the count is unchanged.
    - dec_done is captured into a sticky flag.
    - Go to DONE when rd_remaining=0, wr_remaining=0, outstanding=0 and the sticky flag is set.
  - DONE: pulse done_valid with done_id/done_err for one cycle, pop the FIFO, return to IDLE.
- Request stability: addr and len must not change while rd_req/wr_req is asserted and not yet acknowledged.

## Timing
- Reset values: every output is 0 except job_ready=1 and idle=1. bready=1 from the first cycle after reset release.
- Reset taken mid-job: discard the FIFO contents and all counters, emit no done pulse, return to IDLE.
- Job latency into the FSM: a push at cycle t gives IDLE→START at t+1, dec_start=1 at t+2, and rd_req=1 at t+3 at the earliest.
- Zero-length job: done_valid goes high 2 cycles after IDLE sees the entry. No rd_req, wr_req or dec_start is issued.
- Back-to-back bursts: the next request may be asserted in the cycle after the ack.
- Simultaneous events:
  - A push in the same cycle as the DONE pop is accepted when the FIFO is full-1 or less; job_ready reflects the pre-pop state.
  - dec_done may arrive in any RUN cycle, including before the last bresp.

## Test plan
- Single job, DATA_W=512, src=0x1000, comp_len=4096, decomp_len=8192, MAX_BURST=64 → one read (0x1000, len 63); writes (des, len 63) and (des+0x1000, len 63); one done_valid with done_err=0.
- 4 KB crossing: src=0xFC0, comp_len=128 → two reads (0xFC0, len 0) and (0x1000, len 0).
- Zero length: comp_len=0, id=5 → done_valid with done_id=5 and done_err=1; no rd_req, wr_req or dec_start.
- Queue full: 5 pushes with QUEUE_DEPTH=4 while the first job stalls → job_ready=0 after the 4th push. All 5 jobs complete in ID order.
- Outstanding cap: MAX_WR_OUT=2, bresp withheld → wr_req drops after 2 acks and resumes the cycle after the first bresp.
- Reset mid-RUN, then a new job → no stale done pulse; the new job runs normally. Byte order check: rd_data byte 63 = 0xAB → dec_data byte 0 = 0xAB.

Source files
------------

// File: rtl/dma_job_ctrl_if.sv
// rtl/dma_job_ctrl_if.sv - job queue, request, data and completion signals of dma_job_ctrl
interface dma_job_ctrl_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 512,
  parameter int ID_W   = 4
);
  localparam int BYTES = DATA_W / 8;

  logic              job_valid;
  logic              job_ready;
  logic [ID_W-1:0]   job_id;
  logic [ADDR_W-1:0] job_src_addr;
  logic [ADDR_W-1:0] job_des_addr;
  logic [31:0]       job_comp_len;
  logic [31:0]       job_decomp_len;

  logic              done_valid;
  logic [ID_W-1:0]   done_id;
  logic              done_err;
  logic              idle;

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_len;
  logic              rd_req_ack;
  logic [DATA_W-1:0] rd_data;
  logic              rd_data_valid;
  logic              rd_data_taken;

  logic              dec_start;
  logic [34:0]       dec_comp_len;
  logic [31:0]       dec_decomp_len;
  logic [DATA_W-1:0] dec_data;
  logic              dec_valid;
  logic              dec_almostfull;
  logic [DATA_W-1:0] dec_out;
  logic [BYTES-1:0]  dec_out_strb;
  logic              dec_done;

  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_len;
  logic              wr_req_ack;
  logic [DATA_W-1:0] wr_data;
  logic [BYTES-1:0]  wr_strb;
  logic              wr_valid;
  logic              wr_ready;
  logic              bresp;
  logic              bready;

  modport master (
    input  job_valid, job_id, job_src_addr, job_des_addr, job_comp_len, job_decomp_len,
    output job_ready, done_valid, done_id, done_err, idle,
    output rd_req, rd_addr, rd_len, rd_data_taken,
    input  rd_req_ack, rd_data, rd_data_valid,
    output dec_start, dec_comp_len, dec_decomp_len, dec_data, dec_valid,
    input  dec_almostfull, dec_out, dec_out_strb, dec_done,
    output wr_req, wr_addr, wr_len, wr_data, wr_strb, bready,
    input  wr_req_ack, wr_valid, wr_ready, bresp
  );

  modport slave (
    output job_valid, job_id, job_src_addr, job_des_addr, job_comp_len, job_decomp_len,
    input  job_ready, done_valid, done_id, done_err, idle,
    input  rd_req, rd_addr, rd_len, rd_data_taken,
    output rd_req_ack, rd_data, rd_data_valid,
    input  dec_start, dec_comp_len, dec_decomp_len, dec_data, dec_valid,
    output dec_almostfull, dec_out, dec_out_strb, dec_done,
    input  wr_req, wr_addr, wr_len, wr_data, wr_strb, bready,
    output wr_req_ack, wr_valid, wr_ready, bresp
  );
endinterface

// File: rtl/dma_job_ctrl.sv
// rtl/dma_job_ctrl.sv - queued-job DMA front end for the Snappy decompressor
module dma_job_ctrl #(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 512,
  parameter int QUEUE_DEPTH = 4,
  parameter int MAX_BURST   = 64,
  parameter int MAX_WR_OUT  = 8,
  parameter int ID_W        = 4
) (
  input logic            clk,
  input logic            rst_n,
  dma_job_ctrl_if.master io_bus
);
  localparam int BYTES = DATA_W / 8;
  localparam int BW    = $clog2(BYTES);
  localparam int QW    = $clog2(QUEUE_DEPTH);
  localparam int OW    = $clog2(MAX_WR_OUT + 1);
  localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(BYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_DONE} state_t;

  // Beats needed to cover a byte length, rounded up, without 32-bit overflow.
  function automatic logic [31:0] f_total_beats(input logic [31:0] nbytes);
    logic [32:0] sum;
    logic [32:0] q;
    sum = {1'b0, nbytes} + 33'(BYTES - 1);
    q   = sum >> BW;
    return q[31:0];
  endfunction

  // Largest legal burst: limited by what is left, MAX_BURST and the next 4 KB page edge.
  function automatic logic [31:0] f_burst_beats(input logic [11:0] a_lo, input logic [31:0] rem);
    logic [12:0] room;
    logic [31:0] b;
    room = 13'd4096 - {1'b0, a_lo};
    b    = 32'(room >> BW);
    if (rem < b) b = rem;
    if (32'(MAX_BURST) < b) b = 32'(MAX_BURST);
    return b;
  endfunction

  state_t            r_state;

  logic [ID_W-1:0]   r_q_id   [QUEUE_DEPTH];
  logic [ADDR_W-1:0] r_q_src  [QUEUE_DEPTH];
  logic [ADDR_W-1:0] r_q_des  [QUEUE_DEPTH];
  logic [31:0]       r_q_clen [QUEUE_DEPTH];
  logic [31:0]       r_q_dlen [QUEUE_DEPTH];
  logic [QW-1:0]     r_wr_ptr;
  logic [QW-1:0]     r_rd_ptr;
  logic [QW:0]       r_count;

  logic [ID_W-1:0]   r_job_id;
  logic              r_job_err;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [31:0]       r_rd_rem;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [31:0]       r_wr_rem;
  logic [OW-1:0]     r_out;
  logic              r_dec_seen;

  logic              r_dec_start;
  logic [34:0]       r_dec_clen;
  logic [31:0]       r_dec_dlen;
  logic              r_done_valid;
  logic [ID_W-1:0]   r_done_id;
  logic              r_done_err;
  logic              r_bready;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic [31:0]       w_rd_beats;
  logic [31:0]       w_wr_beats;
  logic              w_rd_req;
  logic              w_wr_req;
  logic              w_rd_fire;
  logic              w_wr_fire;
  logic              w_head_err;
  logic              w_unused;

  assign w_full     = (r_count == (QW+1)'(QUEUE_DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_push     = io_bus.job_valid && !w_full;
  assign w_pop      = (r_state == S_DONE);
  assign w_head_err = (r_q_clen[r_rd_ptr] == '0) || (r_q_dlen[r_rd_ptr] == '0);

  assign w_rd_beats = f_burst_beats(r_rd_addr[11:0], r_rd_rem);
  assign w_wr_beats = f_burst_beats(r_wr_addr[11:0], r_wr_rem);
  assign w_rd_req   = (r_state == S_RUN) && (r_rd_rem != '0);
  assign w_wr_req   = (r_state == S_RUN) && (r_wr_rem != '0) && (r_out < OW'(MAX_WR_OUT));
  assign w_rd_fire  = w_rd_req && io_bus.rd_req_ack;
  assign w_wr_fire  = w_wr_req && io_bus.wr_req_ack;

  assign io_bus.job_ready      = !w_full;
  assign io_bus.idle           = (r_state == S_IDLE) && w_empty;
  assign io_bus.done_valid     = r_done_valid;
  assign io_bus.done_id        = r_done_id;
  assign io_bus.done_err       = r_done_err;
  assign io_bus.rd_req         = w_rd_req;
  assign io_bus.rd_addr        = w_rd_req ? r_rd_addr : '0;
  assign io_bus.rd_len         = w_rd_req ? 8'(w_rd_beats - 32'd1) : '0;
  assign io_bus.wr_req         = w_wr_req;
  assign io_bus.wr_addr        = w_wr_req ? r_wr_addr : '0;
  assign io_bus.wr_len         = w_wr_req ? 8'(w_wr_beats - 32'd1) : '0;
  assign io_bus.dec_start      = r_dec_start;
  assign io_bus.dec_comp_len   = r_dec_clen;
  assign io_bus.dec_decomp_len = r_dec_dlen;
  assign io_bus.dec_valid      = io_bus.rd_data_valid;
  assign io_bus.rd_data_taken  = ~io_bus.dec_almostfull;
  assign io_bus.bready         = r_bready;

  // Beat-level write handshake is owned by the decompressor side, not this block.
  assign w_unused = ^{io_bus.wr_valid, io_bus.wr_ready};

  for (genvar g = 0; g < BYTES; g++) begin : g_rev
    assign io_bus.dec_data[g*8 +: 8] = io_bus.rd_data[(BYTES-1-g)*8 +: 8];
    assign io_bus.wr_data[g*8 +: 8]  = io_bus.dec_out[(BYTES-1-g)*8 +: 8];
    assign io_bus.wr_strb[g]         = io_bus.dec_out_strb[BYTES-1-g];
  end

  // Descriptor storage: addresses are stored already aligned to the bus width.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_id[r_wr_ptr]   <= io_bus.job_id;
      r_q_src[r_wr_ptr]  <= io_bus.job_src_addr & ADDR_MASK;
      r_q_des[r_wr_ptr]  <= io_bus.job_des_addr & ADDR_MASK;
      r_q_clen[r_wr_ptr] <= io_bus.job_comp_len;
      r_q_dlen[r_wr_ptr] <= io_bus.job_decomp_len;
    end
  end

  // Descriptor FIFO pointers; the head stays in place until its job reaches DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + QW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + QW'(1);
      if (w_push && !w_pop)      r_count <= r_count + (QW+1)'(1);
      else if (!w_push && w_pop) r_count <= r_count - (QW+1)'(1);
    end
  end

  // Job sequencer plus the read/write burst generators and write-outstanding tracking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_job_id     <= '0;
      r_job_err    <= 1'b0;
      r_rd_addr    <= '0;
      r_rd_rem     <= '0;
      r_wr_addr    <= '0;
      r_wr_rem     <= '0;
      r_out        <= '0;
      r_dec_seen   <= 1'b0;
      r_dec_start  <= 1'b0;
      r_dec_clen   <= '0;
      r_dec_dlen   <= '0;
      r_done_valid <= 1'b0;
      r_done_id    <= '0;
      r_done_err   <= 1'b0;
      r_bready     <= 1'b0;
    end else begin
      r_bready     <= 1'b1;
      r_dec_start  <= 1'b0;
      r_done_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_job_id   <= r_q_id[r_rd_ptr];
            r_job_err  <= w_head_err;
            r_rd_addr  <= r_q_src[r_rd_ptr];
            r_wr_addr  <= r_q_des[r_rd_ptr];
            r_rd_rem   <= f_total_beats(r_q_clen[r_rd_ptr]);
            r_wr_rem   <= f_total_beats(r_q_dlen[r_rd_ptr]);
            r_dec_clen <= {3'b000, r_q_clen[r_rd_ptr]};
            r_dec_dlen <= r_q_dlen[r_rd_ptr];
            if (w_head_err) begin
              r_state <= S_DONE;
            end else begin
              r_dec_start <= 1'b1;
              r_state     <= S_START;
            end
          end
        end
        S_START: begin
          r_out      <= '0;
          r_dec_seen <= 1'b0;
          r_state    <= S_RUN;
        end
        S_RUN: begin
          if (w_rd_fire) begin
            r_rd_addr <= r_rd_addr + (ADDR_W'(w_rd_beats) << BW);
            r_rd_rem  <= r_rd_rem - w_rd_beats;
          end
          if (w_wr_fire) begin
            r_wr_addr <= r_wr_addr + (ADDR_W'(w_wr_beats) << BW);
            r_wr_rem  <= r_wr_rem - w_wr_beats;
          end
          if (w_wr_fire && !io_bus.bresp) begin
            r_out <= r_out + OW'(1);
          end else if (!w_wr_fire && io_bus.bresp && (r_out != '0)) begin
            r_out <= r_out - OW'(1);
          end
          if (io_bus.dec_done) r_dec_seen <= 1'b1;
          if ((r_rd_rem == '0) && (r_wr_rem == '0) && (r_out == '0) && r_dec_seen) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done_valid <= 1'b1;
          r_done_id    <= r_job_id;
          r_done_err   <= r_job_err;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dma_job_ctrl.sv
// tb/tb_dma_job_ctrl.sv - scoreboard bench for dma_job_ctrl with randomized jobs
module tb_dma_job_ctrl;
  localparam int ADDR_W      = 64;
  localparam int DATA_W      = 512;
  localparam int ID_W        = 4;
  localparam int BYTES       = DATA_W / 8;
  localparam int QUEUE_DEPTH = 4;
  localparam int MAX_BURST   = 64;
  localparam int MAX_WR_OUT  = 2;

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  len;
  } burst_t;
  typedef struct {
    logic [ID_W-1:0] id;
    logic            err;
  } done_t;
  typedef struct {
    logic [31:0] clen;
    logic [31:0] dlen;
  } start_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dma_job_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

  dma_job_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .QUEUE_DEPTH(QUEUE_DEPTH),
    .MAX_BURST(MAX_BURST), .MAX_WR_OUT(MAX_WR_OUT), .ID_W(ID_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .io_bus(bus)
  );

  int errors = 0;
  int checks = 0;

  burst_t exp_rd[$];
  burst_t exp_wr[$];
  done_t  exp_done[$];
  start_t exp_start[$];

  int pend_b = 0;
  int release_b = 0;
  int dd_cnt = 0;
  int wr_acks = 0;
  bit hold_b = 1'b0;
  bit stall_dd = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add_bursts(input logic [63:0] a0, input logic [31:0] nbytes, input bit is_rd);
    longint unsigned addr;
    longint unsigned beats;
    longint unsigned room;
    longint unsigned b;
    burst_t e;
    addr  = a0 - (a0 % BYTES);
    beats = (64'(nbytes) + BYTES - 1) / BYTES;
    while (beats > 0) begin
      room = (4096 - (addr % 4096)) / BYTES;
      b = beats;
      if (b > MAX_BURST) b = MAX_BURST;
      if (b > room) b = room;
      e.addr = addr;
      e.len  = 8'(b - 1);
      if (is_rd) exp_rd.push_back(e);
      else exp_wr.push_back(e);
      addr  += b * BYTES;
      beats -= b;
    end
  endtask

  task automatic model_job(input logic [ID_W-1:0] id, input logic [63:0] src, input logic [63:0] des,
                           input logic [31:0] clen, input logic [31:0] dlen);
    done_t d;
    start_t s;
    d.id  = id;
    d.err = (clen == 0) || (dlen == 0);
    exp_done.push_back(d);
    if (!d.err) begin
      s.clen = clen;
      s.dlen = dlen;
      exp_start.push_back(s);
      add_bursts(src, clen, 1'b1);
      add_bursts(des, dlen, 1'b0);
    end
  endtask

  task automatic push(input logic [ID_W-1:0] id, input logic [63:0] src, input logic [63:0] des,
                      input logic [31:0] clen, input logic [31:0] dlen);
    int n;
    n = 0;
    @(negedge clk);
    bus.job_id = id;
    bus.job_src_addr = src;
    bus.job_des_addr = des;
    bus.job_comp_len = clen;
    bus.job_decomp_len = dlen;
    bus.job_valid = 1'b1;
    while (!bus.job_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      chk("push_timeout", 64'(n), 0);
      bus.job_valid = 1'b0;
    end else begin
      model_job(id, src, des, clen, dlen);
      @(negedge clk);
      bus.job_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    while (!(bus.idle && exp_done.size() == 0 && exp_rd.size() == 0 && exp_wr.size() == 0)
           && n < max_cyc) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("drain_in_time", 64'(n < max_cyc), 1);
  endtask

  // Environment: answers requests, returns B responses, finishes the decompressor and scores outputs.
  always @(negedge clk) begin : env
    burst_t e;
    done_t d;
    start_t s;
    bus.bresp = 1'b0;
    bus.dec_done = 1'b0;
    bus.rd_req_ack = 1'b0;
    bus.wr_req_ack = 1'b0;
    if (!rst_n) begin
      pend_b = 0;
      dd_cnt = 0;
    end else begin
      if (bus.done_valid) begin
        if (exp_done.size() == 0) begin
          chk("done_expected", 64'(exp_done.size()), 1);
        end else begin
          d = exp_done.pop_front();
          chk("done_id", 64'(bus.done_id), 64'(d.id));
          chk("done_err", 64'(bus.done_err), 64'(d.err));
        end
      end
      if (dd_cnt > 0 && !stall_dd) begin
        dd_cnt--;
        if (dd_cnt == 0) bus.dec_done = 1'b1;
      end
      if (bus.dec_start) begin
        if (exp_start.size() == 0) begin
          chk("dec_start_expected", 64'(exp_start.size()), 1);
        end else begin
          s = exp_start.pop_front();
          chk("dec_comp_len", 64'(bus.dec_comp_len), 64'(s.clen));
          chk("dec_decomp_len", 64'(bus.dec_decomp_len), 64'(s.dlen));
        end
        dd_cnt = 1 + int'($urandom_range(0, 20));
      end
      if (pend_b > 0 && ((!hold_b && $urandom_range(0, 2) == 0) || release_b > 0)) begin
        bus.bresp = 1'b1;
        pend_b--;
        if (release_b > 0) release_b--;
      end
      if (bus.rd_req) begin
        if (exp_rd.size() == 0) begin
          chk("rd_req_expected", 64'(exp_rd.size()), 1);
        end else if ($urandom_range(0, 3) != 0) begin
          bus.rd_req_ack = 1'b1;
          e = exp_rd.pop_front();
          chk("rd_addr", bus.rd_addr, e.addr);
          chk("rd_len", 64'(bus.rd_len), 64'(e.len));
        end
      end
      if (bus.wr_req) begin
        if (exp_wr.size() == 0) begin
          chk("wr_req_expected", 64'(exp_wr.size()), 1);
        end else if ($urandom_range(0, 3) != 0) begin
          bus.wr_req_ack = 1'b1;
          e = exp_wr.pop_front();
          chk("wr_addr", bus.wr_addr, e.addr);
          chk("wr_len", 64'(bus.wr_len), 64'(e.len));
          pend_b++;
          wr_acks++;
        end
      end
    end
  end

  initial begin
    logic [DATA_W-1:0] rd_v;
    logic [DATA_W-1:0] out_v;
    logic [DATA_W-1:0] exp_dec;
    logic [DATA_W-1:0] exp_wr_d;
    logic [BYTES-1:0]  strb_v;
    logic [BYTES-1:0]  exp_strb;
    int acks0;
    int stale;
    int n;
    logic [31:0] cl;

    bus.job_valid = 1'b0;
    bus.job_id = '0;
    bus.job_src_addr = '0;
    bus.job_des_addr = '0;
    bus.job_comp_len = '0;
    bus.job_decomp_len = '0;
    bus.rd_data = '0;
    bus.rd_data_valid = 1'b0;
    bus.dec_almostfull = 1'b0;
    bus.dec_out = '0;
    bus.dec_out_strb = '0;
    bus.wr_valid = 1'b0;
    bus.wr_ready = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_job_ready", 64'(bus.job_ready), 1);
    chk("rst_idle", 64'(bus.idle), 1);
    chk("rst_done_valid", 64'(bus.done_valid), 0);
    chk("rst_rd_req", 64'(bus.rd_req), 0);
    chk("rst_wr_req", 64'(bus.wr_req), 0);
    chk("rst_dec_start", 64'(bus.dec_start), 0);
    chk("rst_bready", 64'(bus.bready), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("bready_after_reset", 64'(bus.bready), 1);

    // byte / strobe reversal through the combinational paths
    for (int k = 0; k < 4; k++) begin
      for (int b = 0; b < BYTES; b++) begin
        rd_v[b*8 +: 8]  = 8'($urandom);
        out_v[b*8 +: 8] = 8'($urandom);
      end
      if (k == 0) rd_v[63*8 +: 8] = 8'hAB;
      strb_v = {$urandom, $urandom};
      for (int b = 0; b < BYTES; b++) begin
        exp_dec[b*8 +: 8]  = rd_v[(BYTES-1-b)*8 +: 8];
        exp_wr_d[b*8 +: 8] = out_v[(BYTES-1-b)*8 +: 8];
        exp_strb[b]        = strb_v[BYTES-1-b];
      end
      bus.rd_data = rd_v;
      bus.dec_out = out_v;
      bus.dec_out_strb = strb_v;
      bus.rd_data_valid = k[0];
      bus.dec_almostfull = k[1];
      #1;
      if (k == 0) chk("dec_data_byte0", 64'(bus.dec_data[7:0]), 64'h AB);
      chk("dec_data_reversed", 64'(bus.dec_data == exp_dec), 1);
      chk("wr_data_reversed", 64'(bus.wr_data == exp_wr_d), 1);
      chk("wr_strb_reversed", 64'(bus.wr_strb), 64'(exp_strb));
      chk("dec_valid", 64'(bus.dec_valid), 64'(k[0]));
      chk("rd_data_taken", 64'(bus.rd_data_taken), 64'(!k[1]));
    end
    bus.rd_data_valid = 1'b0;
    bus.dec_almostfull = 1'b0;

    // single job with latency checks: one read, two writes
    push(4'd1, 64'h1000, 64'h20000, 32'd4096, 32'd8192);
    chk("lat_dec_start_t1", 64'(bus.dec_start), 0);
    @(negedge clk);
    chk("lat_dec_start_t2", 64'(bus.dec_start), 1);
    @(negedge clk);
    chk("lat_rd_req_t3", 64'(bus.rd_req), 1);
    wait_idle(3000);

    // 4 KB crossing read, unaligned low address bits ignored
    push(4'd2, 64'hFC0 + 64'h15, 64'h8000, 32'd128, 32'd64);
    wait_idle(3000);

    // zero-length job: done two cycles after IDLE sees it
    push(4'd5, 64'h2000, 64'h3000, 32'd0, 32'd100);
    @(negedge clk);
    chk("zero_done_t2", 64'(bus.done_valid), 0);
    @(negedge clk);
    chk("zero_done_t3", 64'(bus.done_valid), 1);
    wait_idle(3000);

    // queue full while the first job stalls, then in-order completion
    stall_dd = 1'b1;
    for (int i = 1; i <= 4; i++) push(4'(i), 64'(i * 4096), 64'h40000, 32'd64, 32'd128);
    chk("queue_full_ready", 64'(bus.job_ready), 0);
    stall_dd = 1'b0;
    push(4'd5, 64'h9000, 64'h50000, 32'd200, 32'd300);
    wait_idle(5000);

    // write outstanding cap with withheld B responses
    hold_b = 1'b1;
    acks0 = wr_acks;
    push(4'd6, 64'h0, 64'h60000, 32'd64, 32'd20480);
    n = 0;
    while ((wr_acks - acks0) < 2 && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    repeat (6) @(negedge clk);
    #1;
    chk("cap_acks", 64'(wr_acks - acks0), 2);
    chk("cap_wr_req_low", 64'(bus.wr_req), 0);
    release_b = 1;
    @(negedge clk);
    #1;
    chk("cap_wr_req_during_bresp", 64'(bus.wr_req), 0);
    @(negedge clk);
    #1;
    chk("cap_wr_req_resumed", 64'(bus.wr_req), 1);
    hold_b = 1'b0;
    wait_idle(5000);

    // reset in the middle of a job, then a clean job
    hold_b = 1'b1;
    push(4'd7, 64'h10000, 64'h70000, 32'd8192, 32'd8192);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    exp_rd.delete();
    exp_wr.delete();
    exp_done.delete();
    exp_start.delete();
    hold_b = 1'b0;
    release_b = 0;
    repeat (3) @(negedge clk);
    chk("midrst_rd_req", 64'(bus.rd_req), 0);
    chk("midrst_job_ready", 64'(bus.job_ready), 1);
    chk("midrst_idle", 64'(bus.idle), 1);
    rst_n = 1'b1;
    stale = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.done_valid) stale++;
    end
    chk("midrst_no_stale_done", 64'(stale), 0);
    push(4'd8, 64'h3000, 64'h80000, 32'd200, 32'd300);
    wait_idle(3000);

    // randomized jobs, some with zero lengths
    for (int i = 0; i < 12; i++) begin
      cl = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 3000));
      push(4'(i), 64'($urandom), 64'($urandom), cl, 32'($urandom_range(1, 9000)));
    end
    wait_idle(20000);

    chk("left_rd", 64'(exp_rd.size()), 0);
    chk("left_wr", 64'(exp_wr.size()), 0);
    chk("left_start", 64'(exp_start.size()), 0);
    chk("left_done", 64'(exp_done.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
